// File: rtl/phy_dly_sequencer.sv
// Loads a shadow table of phy delay values through the phy programming port.
// Runs either program every entry or only the entries written since their last load.
module phy_dly_sequencer #(
  parameter logic [6:0]  LAST_ADDR     = 7'h5f,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  DLY_DEFAULT   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [6:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       start,
  input  logic       dirty_only,
  output logic       busy,
  output logic       done,
  output logic [7:0] dly_data,
  output logic [6:0] dly_addr,
  output logic       ld_delay,
  output logic       set
);

  typedef enum logic [2:0] {IDLE, SCAN, SET, SETTLE, DONE} state_t;

  localparam logic [7:0]   SETTLE_LAST = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
  localparam logic [127:0] SCAN_MASK   = {128{1'b1}} >> (7'd127 - LAST_ADDR);

  state_t       state, state_nxt;
  logic [6:0]   idx, idx_nxt;
  logic [7:0]   cnt, cnt_nxt;
  logic         dirty_mode, dirty_mode_nxt;

  logic [7:0]   dly_table [128];
  logic [127:0] dirty;

  logic         load_en;
  logic         busy_nxt, done_nxt, ld_nxt, set_nxt;
  logic [7:0]   data_nxt;
  logic [6:0]   addr_nxt;

  // A start on the cycle done is visible must not launch a new run.
  wire accept    = (state == IDLE) && start && !done;
  wire any_dirty = |(dirty & SCAN_MASK);

  assign load_en = (state == SCAN) && (!dirty_mode || dirty[idx]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      dirty_mode <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      dirty_mode <= dirty_mode_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    dirty_mode_nxt = dirty_mode;
    unique case (state)
      IDLE: begin
        if (accept) begin
          idx_nxt        = '0;
          dirty_mode_nxt = dirty_only;
          state_nxt      = (dirty_only && !any_dirty) ? DONE : SCAN;
        end
      end
      SCAN: begin
        idx_nxt = idx + 7'd1;
        if (idx == LAST_ADDR) state_nxt = SET;
      end
      SET: begin
        cnt_nxt   = '0;
        state_nxt = (SETTLE_CYCLES == 0) ? DONE : SETTLE;
      end
      SETTLE: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt == SETTLE_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: values the output flops take at the next edge
  always_comb begin
    busy_nxt = busy;
    done_nxt = 1'b0;
    ld_nxt   = 1'b0;
    set_nxt  = 1'b0;
    addr_nxt = dly_addr;
    data_nxt = dly_data;
    unique case (state)
      IDLE: if (accept) busy_nxt = 1'b1;
      SCAN: begin
        if (load_en) begin
          ld_nxt   = 1'b1;
          addr_nxt = idx;
          data_nxt = dly_table[idx];
        end
      end
      SET:  set_nxt = 1'b1;
      DONE: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      ld_delay <= 1'b0;
      set      <= 1'b0;
      dly_addr <= '0;
      dly_data <= '0;
    end else begin
      busy     <= busy_nxt;
      done     <= done_nxt;
      ld_delay <= ld_nxt;
      set      <= set_nxt;
      dly_addr <= addr_nxt;
      dly_data <= data_nxt;
    end
  end

  // Shadow table and dirty bits. A write on the cycle an entry is loaded
  // lands after the clear, so the entry stays dirty with the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is reset explicitly, so it is built from flops, not RAM;
      // the all-ones dirty vector makes the first dirty-only run load everything.
      for (int i = 0; i < 128; i++) dly_table[i] <= DLY_DEFAULT;
      dirty <= '1;
    end else begin
      if (load_en) dirty[idx] <= 1'b0;
      if (cfg_we) begin
        dly_table[cfg_addr] <= cfg_data;
        dirty[cfg_addr]     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/phy_dly_sequencer.md
PHY_DLY_SEQUENCER -- requirements
Module: phy_dly_sequencer

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 7'h5f, meaning the highest delay address scanned; the scan covers addresses 0..LAST_ADDR, so N = LAST_ADDR+1.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, meaning the idle cycles after the set pulse before done; legal range 0..255.
REQ-003 SHALL have parameter DLY_DEFAULT, default 8'h00, meaning the reset value of every shadow entry.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, the same domain as the phy set strobe (clk_div of the phy).
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_we, input, 1 bit: write strobe for the shadow delay table.
REQ-007 SHALL have port cfg_addr, input, 7 bits: shadow table write address.
REQ-008 SHALL have port cfg_data, input, 8 bits: shadow table write data (3 LSB are the fine delay).
REQ-009 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-010 SHALL have port dirty_only, input, 1 bit: sampled with start; 1 loads only modified entries, 0 loads all entries.
REQ-011 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle run-complete pulse.
REQ-013 SHALL have ports dly_data (output, 8 bits), dly_addr (output, 7 bits), ld_delay (output, 1 bit) and set (output, 1 bit): the phy delay programming port.

Function
REQ-014 SHALL hold a 128x8 shadow table plus one dirty bit per address; a cfg_we write stores cfg_data and sets the dirty bit, accepted in any state; writes with cfg_addr > LAST_ADDR store data but are never scanned.
REQ-015 SHALL implement FSM states IDLE, SCAN, SET, SETTLE, DONE.
REQ-016 IDLE -> SCAN on start=1; the scan index is cleared to 0; busy rises at the same edge; dirty_only is latched.
REQ-017 In dirty-only mode, if no dirty bit in 0..LAST_ADDR is set when start is sampled, the FSM SHALL go IDLE -> DONE directly: no ld_delay, no set, and done is high for the cycle after the next edge.
REQ-018 SCAN SHALL visit one address per cycle: after edge T+1+k, dly_addr=k, dly_data=table[k], and ld_delay=1 iff full mode or dirty[k]; k runs 0..LAST_ADDR.
REQ-019 The dirty bit of every address presented with ld_delay=1 SHALL be cleared, except when cfg_we targets that address on the same cycle, in which case the write wins (dirty stays 1, new data stored) and the old data is the value driven out.
REQ-020 A write during SCAN to an address not yet visited SHALL be loaded in this run; a write to an address already visited SHALL stay dirty for the next run.
REQ-021 After the last address, SET SHALL drive set=1 and ld_delay=0 for exactly one cycle, then SETTLE counts SETTLE_CYCLES cycles (0 means skip).
REQ-022 DONE SHALL assert done for one cycle and deassert busy at the same edge, then return to IDLE.
REQ-023 start while busy SHALL be ignored, not queued; start on the DONE cycle SHALL also be ignored.
REQ-024 Total latency SHALL be: start sampled at edge T, set high after edge T+1+N, done high after edge T+2+N+SETTLE_CYCLES.
REQ-025 ld_delay and set SHALL never be high in the same cycle; dly_addr and dly_data SHALL hold their last values when ld_delay=0.

Reset
REQ-026 rst_n=0 SHALL immediately force the FSM to IDLE, all outputs to 0, table entries to DLY_DEFAULT, and all dirty bits to 1, so the first dirty-only run programs everything.
REQ-027 rst_n asserted mid-run SHALL abort with no set pulse and no done pulse; the phy retains any partially loaded values.
REQ-028 Release of rst_n SHALL take effect at the first clk edge after deassertion.

Verification
REQ-029 Reset then start with dirty_only=0, N=96, SETTLE_CYCLES=4, start at edge 0 -> 96 ld_delay pulses on addr 0..95 at edges 1..96, each with data 8'h00; set at edge 97; done at edge 102; busy high for edges 0..101.
REQ-030 After a full run, write addr 5=8'h2a and addr 40=8'h13, then start with dirty_only=1 -> exactly two ld_delay pulses (5/8'h2a, 40/8'h13), then set, then done at the same latency as a full run.
REQ-031 Dirty-only start with no dirty bits -> done one cycle after start, no ld_delay and no set.
REQ-032 During a full run, write addr 10 on the cycle it is presented and addr 90 at scan index 20 -> addr 10 driven with old data and still dirty; addr 90 loaded with new data and clean.
REQ-033 Assert rst_n=0 at scan index 50 -> outputs 0 immediately, no set and no done; a subsequent dirty-only run loads all 96 entries.
REQ-034 start pulsed at scan index 3 and again on the DONE cycle -> both ignored, exactly one run.
